// File: rtl/memory_playback_pkg.sv
// Shared types and sizing for the host-to-board playback buffer.
// Imported by the interface, the skid FIFO and the top.
package memory_playback_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 10;
    localparam int REPEAT_W = 8;
    localparam int DEPTH    = 1 << ADDR_W;

    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/memory_playback_if.sv
// Host load/control bus plus downstream FIFO write port.
// master = host/driver side, slave = playback block.
interface memory_playback_if;
    import memory_playback_pkg::*;

    logic                din_write;
    logic [DATA_W-1:0]   din;
    logic                zero;
    logic                start;
    logic [REPEAT_W-1:0] repeat_n;
    logic                dout_full;
    logic                dout_write;
    logic [DATA_W-1:0]   dout;
    logic [ADDR_W:0]     word_count;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output din_write, din, zero, start, repeat_n, dout_full,
        input  dout_write, dout, word_count, busy, done, err
    );

    modport slave (
        input  din_write, din, zero, start, repeat_n, dout_full,
        output dout_write, dout, word_count, busy, done, err
    );

endinterface

// File: rtl/memory_playback_skid.sv
// Two-entry FIFO between the block RAM read port and dout.
// head is registered so dout never comes straight off the RAM.
module memory_playback_skid
    import memory_playback_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] tail;

    // Shift-register FIFO: head is always the oldest word.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= data;
                    else             tail <= data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= data;
                    end else begin
                        head <= tail;
                        tail <= data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/memory_playback.sv
// Host fills block RAM, start streams it to a downstream FIFO,
// optionally repeated; read path is throttled so the skid never overflows.
module memory_playback
    import memory_playback_pkg::*;
(
    input logic               clk,
    input logic               rst,
    memory_playback_if.slave  bus
);

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W:0]     count;
    logic [ADDR_W-1:0]   rd_addr;
    logic [REPEAT_W-1:0] passes;
    logic                issuing;
    logic                inflight;
    logic                err;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data;

    logic [1:0]          occ;
    logic [DATA_W-1:0]   head;
    logic                pop;
    logic                issue;
    logic                wr_en;
    logic                wr_drop;
    logic                go;
    logic                last_addr;
    logic [ADDR_W:0]     play_len;
    logic [2:0]          fill;

    assign wr_en   = bus.din_write & ~bus.zero & (state == ST_IDLE)
                   & (count != MAX_COUNT);
    assign wr_drop = bus.din_write & ~bus.zero & ~wr_en;
    assign go      = bus.start & ~bus.zero & (state == ST_IDLE);

    // A write in the start cycle still counts toward this playback.
    assign play_len = count + (ADDR_W+1)'(wr_en);

    assign pop  = (occ != 2'd0) & ~bus.dout_full;
    // Words that will sit in the skid once this cycle's pop is gone.
    assign fill = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign issue = (state == ST_PLAY) & issuing & ~bus.zero
                 & (fill < 3'd2);

    assign last_addr = ({1'b0, rd_addr} == count - (ADDR_W+1)'(1));

    // Next-state logic for IDLE/PLAY/DONE.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (go) state_nx = (play_len != '0) ? ST_PLAY : ST_DONE;
            end
            ST_PLAY: begin
                if (bus.zero)
                    state_nx = ST_IDLE;
                else if (~issuing & ~inflight & (occ == 2'd0))
                    state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, load count, read pointer, pass counter and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            rd_addr  <= '0;
            passes   <= '0;
            issuing  <= 1'b0;
            inflight <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            if (bus.zero) begin
                count    <= '0;
                rd_addr  <= '0;
                err      <= 1'b0;
                issuing  <= 1'b0;
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (wr_en)   count <= count + (ADDR_W+1)'(1);
                if (wr_drop) err   <= 1'b1;
                if (go) begin
                    rd_addr <= '0;
                    passes  <= bus.repeat_n;
                    issuing <= (play_len != '0);
                end else if (issue) begin
                    if (!last_addr) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end else if (passes != '0) begin
                        passes  <= passes - REPEAT_W'(1);
                        rd_addr <= '0;
                    end else begin
                        issuing <= 1'b0;
                    end
                end
            end
        end
    end

    // Dual-port block RAM: port A host write, port B playback read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[count[ADDR_W-1:0]] <= bus.din;
        if (issue) rd_data <= mem[rd_addr];
    end

    memory_playback_skid u_skid (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.zero),
        .push  (inflight),
        .pop   (pop),
        .data  (rd_data),
        .occ   (occ),
        .head  (head)
    );

    assign bus.dout_write = pop;
    assign bus.dout       = head;
    assign bus.word_count = count;
    assign bus.busy       = (state == ST_PLAY);
    assign bus.done       = (state == ST_DONE);
    assign bus.err        = err;

endmodule

// File: tb/tb_memory_playback.sv
// Directed and randomized checks of memory_playback against a
// queue-based model of stored words and expected output stream.
module tb_memory_playback;
    import memory_playback_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_playback_if bus ();

    memory_playback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    bit mon_en      = 1'b0;
    bit ref_err     = 1'b0;

    logic [31:0] ref_mem [$];
    logic [31:0] got [$];
    int          got_edge [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Collect every accepted transfer and done pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.dout_full === 1'b1)
                chk("no_write_when_full", 64'(bus.dout_write), 64'd0);
            if (bus.dout_write === 1'b1) begin
                got.push_back(bus.dout);
                got_edge.push_back(cyc + 1);
            end
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        bus.din_write = 1'b1;
        bus.din       = d;
        step();
        bus.din_write = 1'b0;
        if (ref_mem.size() < DEPTH) ref_mem.push_back(d);
        else                        ref_err = 1'b1;
    endtask

    task automatic do_zero();
        bus.zero = 1'b1;
        step();
        bus.zero = 1'b0;
        ref_mem.delete();
        ref_err = 1'b0;
    endtask

    task automatic start_only(input int rep, output int t0);
        got.delete();
        got_edge.delete();
        done_cnt     = 0;
        bus.start    = 1'b1;
        bus.repeat_n = REPEAT_W'(rep);
        step();
        t0        = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit rnd_full,
                             input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            bus.dout_full = rnd_full ? ($urandom_range(0, 2) == 0) : 1'b0;
            step();
        end
        bus.dout_full = 1'b0;
        repeat (3) step();
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic check_stream(input string tag, input int rep);
        logic [31:0] exp [$];
        exp = {};
        for (int p = 0; p <= rep; p++)
            foreach (ref_mem[i]) exp.push_back(ref_mem[i]);
        chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk({tag, "_data"}, 64'(got[i]), 64'(exp[i]));
    endtask

    initial begin
        int  t0;
        bit  found;
        bus.din_write = 1'b0;
        bus.din       = '0;
        bus.zero      = 1'b0;
        bus.start     = 1'b0;
        bus.repeat_n  = '0;
        bus.dout_full = 1'b0;
        rst = 1'b1;
        repeat (3) step();

        chk("rst_dout_write", 64'(bus.dout_write), 64'd0);
        chk("rst_dout",       64'(bus.dout),       64'd0);
        chk("rst_busy",       64'(bus.busy),       64'd0);
        chk("rst_done",       64'(bus.done),       64'd0);
        chk("rst_err",        64'(bus.err),        64'd0);
        chk("rst_count",      64'(bus.word_count), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step();

        // Three words, single pass: latency and order.
        write_word(32'h11);
        write_word(32'h22);
        write_word(32'h33);
        start_only(0, t0);
        chk("t1_busy", 64'(bus.busy), 64'd1);
        wait_done("t1", 1'b0, 50);
        check_stream("t1", 0);
        if (got_edge.size() > 0)
            chk("t1_first_edge", 64'(got_edge[0]), 64'(t0 + 3));
        chk("t1_count", 64'(bus.word_count), 64'd3);

        // Three passes, no bubble at the wrap.
        start_only(2, t0);
        wait_done("t2", 1'b0, 50);
        check_stream("t2", 2);
        for (int i = 1; i < got_edge.size(); i++)
            chk("t2_contig", 64'(got_edge[i]), 64'(got_edge[0] + i));
        chk("t2_count", 64'(bus.word_count), 64'd3);

        // Full RAM, overflow write, randomized backpressure.
        do_zero();
        for (int i = 0; i < DEPTH; i++) write_word($urandom);
        chk("t4_count_full", 64'(bus.word_count), 64'(DEPTH));
        chk("t4_err_clear",  64'(bus.err),        64'(ref_err));
        write_word($urandom);
        chk("t4_count_sat",  64'(bus.word_count), 64'(DEPTH));
        chk("t4_err_set",    64'(bus.err),        64'(ref_err));
        start_only(0, t0);
        wait_done("t3", 1'b1, 4000);
        check_stream("t3", 0);
        do_zero();
        chk("t4_zero_count", 64'(bus.word_count), 64'd0);
        chk("t4_zero_err",   64'(bus.err),        64'd0);

        // zero while the fifth word is on the bus.
        for (int i = 0; i < 8; i++) write_word($urandom);
        start_only(0, t0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (got.size() == 4 && bus.dout_write === 1'b1) found = 1'b1;
        end
        chk("t5_zero_point", 64'(found), 64'd1);
        do_zero();
        chk("t5_zero_dw",    64'(bus.dout_write), 64'd0);
        chk("t5_zero_busy",  64'(bus.busy),       64'd0);
        chk("t5_zero_count", 64'(bus.word_count), 64'd0);
        repeat (10) step();
        chk("t5_zero_nodone", 64'(done_cnt),   64'd0);
        chk("t5_zero_words",  64'(got.size()), 64'd5);

        // Reset in the middle of playback.
        for (int i = 0; i < 8; i++) write_word($urandom);
        start_only(1, t0);
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ref_mem.delete();
        ref_err = 1'b0;
        chk("t5_rst_dw",    64'(bus.dout_write), 64'd0);
        chk("t5_rst_busy",  64'(bus.busy),       64'd0);
        chk("t5_rst_count", 64'(bus.word_count), 64'd0);
        repeat (10) step();
        chk("t5_rst_nodone", 64'(done_cnt), 64'd0);

        // Start with nothing stored.
        start_only(0, t0);
        chk("t5_empty_busy", 64'(bus.busy), 64'd0);
        repeat (5) step();
        chk("t5_empty_done",  64'(done_cnt),   64'd1);
        chk("t5_empty_words", 64'(got.size()), 64'd0);

        // Write during PLAY is dropped and flags err.
        for (int i = 0; i < 3; i++) write_word($urandom);
        start_only(0, t0);
        bus.din_write = 1'b1;
        bus.din       = $urandom;
        step();
        bus.din_write = 1'b0;
        ref_err = 1'b1;
        wait_done("t6_drop", 1'b0, 50);
        check_stream("t6_drop", 0);
        chk("t6_drop_err",   64'(bus.err),        64'(ref_err));
        chk("t6_drop_count", 64'(bus.word_count), 64'd3);

        // start together with a write: the word is played.
        do_zero();
        chk("t6_zero_err", 64'(bus.err), 64'd0);
        write_word($urandom);
        write_word($urandom);
        bus.din_write = 1'b1;
        bus.din       = $urandom;
        ref_mem.push_back(bus.din);
        start_only(0, t0);
        bus.din_write = 1'b0;
        wait_done("t6_join", 1'b0, 50);
        check_stream("t6_join", 0);
        chk("t6_join_count", 64'(bus.word_count), 64'd3);
        chk("t6_join_err",   64'(bus.err),        64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
